// File: rtl/halt_state_dumper.sv
// -----------------------------------------------------------------------------
// halt_state_dumper
//   When the CPU raises halt, this block streams every register-file word and
//   then every data-memory word out over a valid/ready port. It reads the RF and
//   DMEM through their combinational read ports.
//
// Handshake: a word moves on a rising edge where out_valid && out_ready. While
//   out_valid is high and out_ready is low, out_data/out_sel/out_last are held.
//   out_valid never depends combinationally on out_ready.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   halt       CPU halt flag, sampled in IDLE and DONE only
//   rf_addr    RF read address (0 outside REGS)
//   rf_data    RF read data, combinational from rf_addr
//   mem_addr   DMEM byte address (MEM_BASE outside MEM)
//   mem_data   DMEM read data, combinational from mem_addr
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word this cycle
//   out_data   dumped word
//   out_sel    0 = register word, 1 = memory word
//   out_last   high with the final memory word only
//   busy       high in REGS or MEM
//   done       high in DONE
//   state_dbg  current FSM state (0 IDLE, 1 REGS, 2 MEM, 3 DONE)
// -----------------------------------------------------------------------------
module halt_state_dumper #(
  parameter int          NREGS     = 32,
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] MEM_BASE  = 32'h0,
  parameter int          WORD_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  output logic [4:0]        rf_addr,
  input  logic [WORD_W-1:0] rf_data,
  output logic [31:0]       mem_addr,
  input  logic [WORD_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_sel,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  localparam int MIW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [4:0]     REG_LAST = 5'(NREGS - 1);
  localparam logic [MIW-1:0] MEM_LAST = MIW'(MEM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REGS = 2'd1,
    MEM  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [4:0]         reg_idx, reg_nxt;
  logic [MIW-1:0]     mem_idx, mem_nxt, mem_inc;
  logic               valid_nxt, sel_nxt, last_nxt;
  logic [WORD_W-1:0]  data_nxt;
  logic [4:0]         rf_a;
  logic [MIW-1:0]     mem_a;
  logic               fire;

  assign fire    = out_valid && out_ready;
  assign mem_inc = mem_idx + 1'b1;

  // Next-state and output-register logic. On a handshake the read addresses
  // look ahead to the next word so it can be loaded on the same edge, giving
  // one word per cycle with out_ready held high.
  always_comb begin
    state_nxt = state;
    reg_nxt   = reg_idx;
    mem_nxt   = mem_idx;
    valid_nxt = out_valid;
    data_nxt  = out_data;
    sel_nxt   = out_sel;
    last_nxt  = out_last;
    rf_a      = '0;
    mem_a     = '0;
    case (state)
      IDLE: begin
        if (halt) begin
          valid_nxt = 1'b1;
          data_nxt  = rf_data;      // rf_a = 0 here, so this is register 0
          sel_nxt   = 1'b0;
          last_nxt  = 1'b0;
          reg_nxt   = '0;
          mem_nxt   = '0;
          state_nxt = REGS;
        end
      end
      REGS: begin
        rf_a = reg_idx;
        if (fire) begin
          if (reg_idx == REG_LAST) begin
            // mem_a is 0 here, so mem_data is the word at MEM_BASE
            data_nxt  = mem_data;
            sel_nxt   = 1'b1;
            last_nxt  = (MEM_WORDS == 1);
            state_nxt = MEM;
          end else begin
            rf_a     = reg_idx + 5'd1;
            reg_nxt  = reg_idx + 5'd1;
            data_nxt = rf_data;
          end
        end
      end
      MEM: begin
        mem_a = mem_idx;
        if (fire) begin
          if (mem_idx == MEM_LAST) begin
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            state_nxt = DONE;
          end else begin
            mem_a    = mem_inc;
            mem_nxt  = mem_inc;
            data_nxt = mem_data;
            last_nxt = (mem_inc == MEM_LAST);
          end
        end
      end
      DONE: begin
        // Stay here until halt drops so a held halt cannot retrigger a dump.
        if (!halt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      reg_idx   <= '0;
      mem_idx   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nxt;
      reg_idx   <= reg_nxt;
      mem_idx   <= mem_nxt;
      out_valid <= valid_nxt;
      out_data  <= data_nxt;
      out_sel   <= sel_nxt;
      out_last  <= last_nxt;
    end
  end

  assign rf_addr   = rf_a;
  assign mem_addr  = MEM_BASE + (32'(mem_a) << 2);
  assign busy      = (state == REGS) || (state == MEM);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_halt_state_dumper.sv
// -----------------------------------------------------------------------------
// tb_halt_state_dumper
//   Bench for halt_state_dumper. RF and DMEM are modelled as combinational
//   lookups (RF[i] = i*0x11, DMEM[j] = 0xA0000000 + j). Each dump pushes its
//   288 expected words {sel,last,data} into exp_q; a monitor pops and compares
//   on every accepted word and checks that stalled words are held.
// -----------------------------------------------------------------------------
module tb_halt_state_dumper;

  localparam int          NREGS     = 32;
  localparam int          MEM_WORDS = 256;
  localparam logic [31:0] MEM_BASE  = 32'h0;
  localparam int          W         = 34;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // DUT signals
  logic        halt;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sel;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  halt_state_dumper #(
    .NREGS(NREGS), .MEM_WORDS(MEM_WORDS), .MEM_BASE(MEM_BASE), .WORD_W(32)
  ) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // attached memory models
  assign rf_data  = {27'b0, rf_addr} * 32'h11;
  assign mem_data = 32'hA000_0000 + ((mem_addr - MEM_BASE) >> 2);

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int first_cyc = 0;
  int last_cyc  = 0;
  int ready_mode = 0;   // 0 always ready, 1 random 30% stall, 2 seam stall
  int stall_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ready driver
  initial out_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 99) >= 30);
      2: begin
        if (out_valid && !out_sel && n_acc == 31 && stall_n < 5) begin
          out_ready = 1'b0;
          stall_n++;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  // monitor
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_word  = '0;
  always @(negedge clk) begin
    logic [W-1:0] cur;
    logic [W-1:0] e;
    cur = {out_sel, out_last, out_data};
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (!out_valid || cur !== prev_word) begin
          bad++;
          $display("FAIL hold: got v=%0b w=%h want v=1 w=%h", out_valid, cur, prev_word);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got %h want none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            bad++;
            $display("FAIL word[%0d]: got %h want %h", n_acc, cur, e);
          end
        end
        if (n_acc == 0) first_cyc = cyc;
        last_cyc = cyc;
        n_acc++;
      end
      if (ready_mode == 2 && out_valid && !out_ready && n_acc == 31) begin
        total++;
        if (mem_addr !== MEM_BASE) begin
          bad++;
          $display("FAIL seam_mem_addr: got %h want %h", mem_addr, MEM_BASE);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = cur;
    end
  end

  // driver tasks
  task automatic push_dump();
    for (int i = 0; i < NREGS; i++)
      exp_q.push_back({1'b0, 1'b0, 32'(i) * 32'h11});
    for (int j = 0; j < MEM_WORDS; j++)
      exp_q.push_back({1'b1, (j == MEM_WORDS - 1), 32'hA000_0000 + 32'(j)});
  endtask

  task automatic start_dump(input bit hold);
    n_acc = 0;
    push_dump();
    @(posedge clk); #1 halt = 1'b1;
    @(posedge clk); #1 halt = hold;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 3000 && !done; k++) @(negedge clk);
    chk({name, "_done"}, done, 1);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_words"}, n_acc, NREGS + MEM_WORDS);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b0;
    halt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_mem_addr", mem_addr, MEM_BASE);
    rst = 1'b1;

    // 1: asynchronous reset in the middle of MEM
    ready_mode = 0;
    start_dump(0);
    for (int k = 0; k < 500 && state_dbg != 2'd2; k++) @(negedge clk);
    chk("t1_reached_mem", state_dbg, 2);
    repeat (3) @(negedge clk);
    chk("t1_valid_before", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("t1_valid", out_valid, 0);
    chk("t1_busy", busy, 0);
    chk("t1_state", state_dbg, 0);
    chk("t1_sel", out_sel, 0);
    chk("t1_data", out_data, 0);
    exp_q.delete();
    @(negedge clk) rst = 1'b1;

    // 2: full dump with out_ready always high
    start_dump(0);
    wait_done("t2");
    chk("t2_consecutive", last_cyc - first_cyc, NREGS + MEM_WORDS - 1);
    @(posedge clk); #1;
    chk("t2_idle_after", state_dbg, 0);

    // 3: random backpressure
    ready_mode = 1;
    start_dump(0);
    wait_done("t3");

    // 4: five-cycle stall on register 31
    ready_mode = 2;
    stall_n = 0;
    start_dump(0);
    wait_done("t4");
    chk("t4_stall_cycles", stall_n, 5);

    // 5: halt held after DONE does not retrigger; re-arm after drop
    ready_mode = 0;
    start_dump(1);
    wait_done("t5a");
    repeat (10) @(negedge clk);
    chk("t5_done_held", done, 1);
    chk("t5_busy_held", busy, 0);
    chk("t5_valid_held", out_valid, 0);
    @(posedge clk); #1 halt = 1'b0;
    @(posedge clk); #1;
    chk("t5_idle", state_dbg, 0);
    chk("t5_done_low", done, 0);
    start_dump(0);
    wait_done("t5b");

    // 6: halt dropped during REGS does not abort
    n_acc = 0;
    push_dump();
    @(posedge clk); #1 halt = 1'b1;
    repeat (5) @(posedge clk);
    #1 halt = 1'b0;
    chk("t6_busy_regs", state_dbg, 1);
    wait_done("t6");
    @(posedge clk); #1;
    chk("t6_idle", state_dbg, 0);
    chk("t6_done_low", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
